// File: rtl/updown_seq_pkg.sv
// Shared encodings and default widths for the up/down count sequencer.
package updown_seq_pkg;

  localparam int DEF_W  = 4;
  localparam int DEF_PW = 4;

  typedef enum logic [1:0] {
    MODE_UP       = 2'd0,
    MODE_DOWN     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_FREE     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/updown_count_core.sv
// Plain W-bit up/down counter: load takes priority over a step; wraps modulo 2^W.
module updown_count_core #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         up_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (en_i)
      count_d = up_i ? count_q + W'(1) : count_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/updown_count_sequencer.sv
// Command-driven sequencer running a counter through UP/DOWN/PINGPONG/FREE runs.
// Accept edge loads start; steps begin on the next edge; done/err/aborted are 1-cycle pulses.
module updown_count_sequencer
  import updown_seq_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int PW = DEF_PW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_mode,
  input  logic [W-1:0]  cmd_start,
  input  logic [W-1:0]  cmd_limit,
  input  logic [PW-1:0] cmd_passes,
  input  logic          pause,
  input  logic          abort,
  output logic [W-1:0]  count,
  output logic          dir,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          aborted
);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [W-1:0]  start_q, start_d;
  logic [W-1:0]  limit_q, limit_d;
  logic [PW-1:0] legs_q, legs_d;
  logic          dir_q, dir_d;
  logic          err_q, err_d;
  logic          aborted_q, aborted_d;

  logic          core_load, core_en, core_up;
  logic [W-1:0]  target;
  mode_e         cmd_mode_e;

  assign cmd_mode_e = mode_e'(cmd_mode);
  // A PINGPONG downward leg terminates back at the original start value.
  assign target = (mode_q == MODE_PINGPONG && !dir_q) ? start_q : limit_q;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    start_d   = start_q;
    limit_d   = limit_q;
    legs_d    = legs_q;
    dir_d     = dir_q;
    err_d     = 1'b0;
    aborted_d = 1'b0;
    core_load = 1'b0;
    core_en   = 1'b0;
    core_up   = dir_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          mode_d    = cmd_mode_e;
          start_d   = cmd_start;
          limit_d   = cmd_limit;
          legs_d    = (cmd_passes == '0) ? PW'(1) : cmd_passes;
          dir_d     = (cmd_mode_e != MODE_DOWN);
          core_load = 1'b1;
          if (cmd_mode_e == MODE_PINGPONG && !(cmd_limit > cmd_start)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (pause) begin
          state_d = RUN;
        end else if (mode_q != MODE_FREE && count == target) begin
          if (mode_q == MODE_PINGPONG && legs_q > PW'(1)) begin
            // Turn around without a dwell cycle: flip and step on the same edge.
            legs_d  = legs_q - PW'(1);
            dir_d   = !dir_q;
            core_en = 1'b1;
            core_up = !dir_q;
          end else begin
            state_d = DONE;
          end
        end else begin
          core_en = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= MODE_UP;
      start_q   <= '0;
      limit_q   <= '0;
      legs_q    <= '0;
      dir_q     <= 1'b1;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      start_q   <= start_d;
      limit_q   <= limit_d;
      legs_q    <= legs_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  updown_count_core #(.W(W)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load_i     (core_load),
    .load_val_i (cmd_start),
    .en_i       (core_en),
    .up_i       (core_up),
    .count_o    (count)
  );

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign dir       = dir_q;
  assign err       = err_q;
  assign aborted   = aborted_q;

endmodule
